alu4_sched: RTL and testbench
=============================

Name: alu4_sched

Overview:
- Scheduler that shares one 4-bit ALU (3-bit op select, 4-bit A/B, 4-bit combinational result) between NREQ requesters.
- Arbitrates requests, drives the shared ALU operand and op ports from registers, captures the result after a fixed latency, and returns it on a single response channel tagged with the requester index.
- Sits between the requesting units and the shared ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ALU_LAT, 1, cycles the ALU inputs are held before the result is captured (>=1).
- DW, 4, operand and result width (fixed at 4 for the shared ALU).
- OPW, 3, op select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_op  in  NREQ*OPW  flattened op selects; requester i at bits [i*OPW +: OPW].
- req_a  in  NREQ*DW  flattened A operands.
- req_b  in  NREQ*DW  flattened B operands.
- alu_op  out  OPW  registered op select to the shared ALU.
- alu_a  out  DW  registered A to the ALU.
- alu_b  out  DW  registered B to the ALU.
- alu_result  in  DW  ALU combinational output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  DW  captured ALU result.
- rsp_id  out  IDW  granted requester index; IDW = max(1, $clog2(NREQ)).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, immediate): state IDLE; alu_op/alu_a/alu_b, rsp_valid, rsp_data, rsp_id, busy all 0; req_ready 0; RR pointer = NREQ-1, so requester 0 wins first.
- Reset mid-operation discards the in-flight op; no response is ever produced for it.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner g gets req_ready[g]=1 combinationally in that cycle. req_ready is 0 in all other states.
  - On the edge: alu_* <= req fields of g, rsp_id <= g, count <= ALU_LAT-1, state <= WAIT.
- Arbitration:
  - Round-robin, searching from pointer+1 with wrap at NREQ-1 -> 0.
  - Pointer <= g on each grant; it is unchanged when nothing is granted.
- WAIT:
  - alu_* held stable.
  - When count==0: rsp_data <= alu_result, state <= RESP. Otherwise count decrements.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id stable until rsp_valid & rsp_ready.
  - On that handshake, state <= IDLE. No new acceptance occurs in the same cycle.
- Latency:
  - Accept at cycle 0; rsp_valid first high at cycle ALU_LAT+1.
  - Minimum issue interval is ALU_LAT+2 cycles.
- alu_* keep their last values in IDLE and RESP; they are not zeroed.
- Requesters hold valid and payload until ready. Dropping valid without a handshake simply removes the request from arbitration.
- Results are DW-bit, taken verbatim from alu_result; no width extension, no carry.

Optional Feature:
- Macro ALU4_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index always wins; the RR pointer logic is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package alu4_sched_pkg: state enum (IDLE, WAIT, RESP); constants DW=4 and OPW=3; an IDW helper function.
- One sub-module alu4_rr_arb: combinational grant plus registered pointer, with the fixed-priority variant under the macro.

Test Plan:
- Single request, bench ALU model ADD: req1 op=000 a=1100 b=0011 -> req_ready=0010 at cycle 0; alu_op/a/b = 000/1100/0011 from cycle 1; rsp_valid at cycle 2 with rsp_data=1111, rsp_id=1.
- Fairness: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. With ALU4_SCHED_FIXED_PRIO_EN: 0,0,0,0.
- RR wrap: after a grant to 3, only req0 and req2 valid -> req0 granted next, then req2.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid=1 with rsp_data/rsp_id stable, req_ready=0000, busy=1 throughout; release -> IDLE next cycle.
- Reset in WAIT: assert rst mid-cycle -> busy, rsp_valid and alu_* drop to 0 without waiting for a clock edge; no response. After release, req0 and req3 valid -> req0 granted.
- ALU_LAT=3: model changes alu_result each cycle -> rsp_data equals the value present in the third WAIT cycle; rsp_valid at cycle 4.

Source files
------------

// File: rtl/alu4_sched_pkg.sv
// Shared types and constants for the alu4_sched scheduler.
// The ALU4_SCHED_FIXED_PRIO_EN build option is consumed by alu4_rr_arb.
package alu4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DW  = 4;
    localparam int OPW = 3;

    // Bits needed to hold an index 0..n-1, never less than one.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu4_rr_arb.sv
// Requester arbiter: combinational one-hot grant, registered round-robin pointer.
// Define ALU4_SCHED_FIXED_PRIO_EN for fixed lowest-index priority (no pointer).
module alu4_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = alu4_sched_pkg::idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

`ifdef ALU4_SCHED_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en_i};

    always_comb begin
        gnt_id_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) gnt_id_o = IDW'(i);
        end
        gnt_vld_o = |req_i;
        gnt_o     = gnt_vld_o ? (NREQ'(1) << gnt_id_o) : '0;
    end
`else
    logic [IDW-1:0] ptr_q;
    int             idx;

    // Walk offsets from far to near so the entry right after ptr_q wins.
    always_comb begin
        gnt_id_o = '0;
        idx      = 0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (req_i[idx]) gnt_id_o = IDW'(idx);
        end
        gnt_vld_o = |req_i;
        gnt_o     = gnt_vld_o ? (NREQ'(1) << gnt_id_o) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    ptr_q <= IDW'(NREQ - 1);
        else if (en_i && gnt_vld_o) ptr_q <= gnt_id_o;
    end
`endif

endmodule

// File: rtl/alu4_sched.sv
// Time-shares one 4-bit ALU among NREQ requesters: accept, hold operands, capture, respond.
// Arbitration is round-robin unless ALU4_SCHED_FIXED_PRIO_EN is defined.
module alu4_sched #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1,
    parameter int DW      = alu4_sched_pkg::DW,
    parameter int OPW     = alu4_sched_pkg::OPW,
    localparam int IDW    = alu4_sched_pkg::idw(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    output logic [OPW-1:0]      alu_op,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    input  logic [DW-1:0]       alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);
    import alu4_sched_pkg::*;

    localparam int CW = idw(ALU_LAT);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [OPW-1:0]  alu_op_q;
    logic [DW-1:0]   alu_a_q, alu_b_q, rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;
    logic            in_idle;

    assign in_idle = (state_q == IDLE);

    alu4_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .en_i      (in_idle),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = WAIT;
            WAIT:    if (count_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is also masked by rst so a held request sees no accept during reset.
    always_comb begin
        req_ready = (in_idle && !rst) ? gnt : '0;
        rsp_valid = (state_q == RESP);
        busy      = !in_idle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            count_q    <= '0;
        end else if (in_idle && gnt_vld) begin
            alu_op_q <= req_op[gnt_id*OPW +: OPW];
            alu_a_q  <= req_a[gnt_id*DW +: DW];
            alu_b_q  <= req_b[gnt_id*DW +: DW];
            rsp_id_q <= gnt_id;
            count_q  <= CW'(ALU_LAT - 1);
        end else if (state_q == WAIT) begin
            if (count_q == '0) rsp_data_q <= alu_result;
            else               count_q    <= count_q - CW'(1);
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu4_sched.sv
// Randomized self-checking bench for alu4_sched (ALU_LAT=1 main instance, ALU_LAT=3 side instance).
// Expected grant order follows ALU4_SCHED_FIXED_PRIO_EN when defined.
module tb_alu4_sched;
    localparam int NREQ = 4, DW = 4, OPW = 3, IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]     req_valid, req_ready, req_valid3, req_ready3;
    logic [NREQ*OPW-1:0] req_op, req_op3;
    logic [NREQ*DW-1:0]  req_a, req_b, req_a3, req_b3;
    logic [OPW-1:0]      alu_op, alu_op3;
    logic [DW-1:0]       alu_a, alu_b, alu_result, alu_a3, alu_b3, alu_result3;
    logic                rsp_valid, rsp_valid3, rsp_ready, busy, busy3;
    logic [DW-1:0]       rsp_data, rsp_data3;
    logic [IDW-1:0]      rsp_id, rsp_id3;
    logic [3:0]          cnt3;

    int tests = 0;
    int fails = 0;
    int ptr   = NREQ - 1;

    function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    always @(posedge clk or posedge rst) begin
        if (rst) cnt3 <= 4'd0;
        else     cnt3 <= cnt3 + 4'd1;
    end
    assign alu_result3 = cnt3;

    alu4_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
    );

    alu4_sched #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
        .rsp_id(rsp_id3), .busy(busy3)
    );

    function automatic int exp_grant(input logic [3:0] m);
`ifdef ALU4_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0; req_valid3 = '0; rsp_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        ptr = NREQ - 1;
    endtask

    // One full transaction against the model; hold = cycles of rsp_ready low in RESP.
    task automatic do_txn(input logic [3:0] mask, input int hold, output int g);
        logic [2:0] op;
        logic [3:0] a, b, exp_d;
        int lat;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*OPW +: OPW] = 3'($urandom);
            req_a[i*DW +: DW]    = 4'($urandom);
            req_b[i*DW +: DW]    = 4'($urandom);
        end
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        g = exp_grant(mask);
        op = req_op[g*OPW +: OPW];
        a  = req_a[g*DW +: DW];
        b  = req_b[g*DW +: DW];
        exp_d = alu_fn(op, a, b);
        tests++;
        if (req_ready !== 4'(1 << g)) begin
            $display("FAIL grant mask=%b got req_ready=%b want %b", mask, req_ready, 4'(1 << g)); fails++;
        end
        ptr = g;
        tick;
        tests++;
        if ({alu_op, alu_a, alu_b} !== {op, a, b} || busy !== 1'b1 || req_ready !== 4'b0) begin
            $display("FAIL alu_drive got %h/%h/%h busy=%b rdy=%b want %h/%h/%h busy=1 rdy=0",
                     alu_op, alu_a, alu_b, busy, req_ready, op, a, b); fails++;
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        tests++;
        if (lat != 2) begin $display("FAIL latency got %0d want 2", lat); fails++; end
        for (int h = 0; h < hold; h++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== IDW'(g) || req_ready !== 4'b0 || busy !== 1'b1) begin
                $display("FAIL backpressure cyc=%0d got v=%b d=%h id=%0d rdy=%b busy=%b want v=1 d=%h id=%0d rdy=0 busy=1",
                         h, rsp_valid, rsp_data, rsp_id, req_ready, busy, exp_d, g); fails++;
            end
            tick;
        end
        rsp_ready = 1'b1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== IDW'(g)) begin
            $display("FAIL response got v=%b d=%h id=%0d want v=1 d=%h id=%0d", rsp_valid, rsp_data, rsp_id, exp_d, g); fails++;
        end
        tick;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL return_idle got busy=%b v=%b want 0 0", busy, rsp_valid); fails++;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0; req_valid3 = '0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;
        tick;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0 || {alu_op, alu_a, alu_b} !== 11'b0 ||
            rsp_data !== 4'b0 || rsp_id !== 2'b0) begin
            $display("FAIL reset_state busy=%b v=%b rdy=%b alu=%h/%h/%h d=%h id=%0d want all 0",
                     busy, rsp_valid, req_ready, alu_op, alu_a, alu_b, rsp_data, rsp_id); fails++;
        end
        rst = 1'b0;
        ptr = NREQ - 1;
    endtask

    task automatic test_single;
        do_reset;
        req_op[1*OPW +: OPW] = 3'b000;
        req_a[1*DW +: DW] = 4'b1100;
        req_b[1*DW +: DW] = 4'b0011;
        req_valid = 4'b0010;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin $display("FAIL single_ready got %b want 0010", req_ready); fails++; end
        tick;
        req_valid = '0;
        tests++;
        if ({alu_op, alu_a, alu_b} !== {3'b000, 4'b1100, 4'b0011} || rsp_valid !== 1'b0) begin
            $display("FAIL single_alu got %b/%b/%b v=%b want 000/1100/0011 v=0", alu_op, alu_a, alu_b, rsp_valid); fails++;
        end
        tick;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'b1111 || rsp_id !== 2'd1) begin
            $display("FAIL single_rsp got v=%b d=%b id=%0d want 1 1111 1", rsp_valid, rsp_data, rsp_id); fails++;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        ptr = 1;
    endtask

    task automatic test_fairness;
        int g;
        int want [5];
`ifdef ALU4_SCHED_FIXED_PRIO_EN
        want = '{0, 0, 0, 0, 0};
`else
        want = '{0, 1, 2, 3, 0};
`endif
        do_reset;
        for (int n = 0; n < 5; n++) begin
            do_txn(4'b1111, 0, g);
            tests++;
            if (g != want[n]) begin $display("FAIL fairness n=%0d got %0d want %0d", n, g, want[n]); fails++; end
        end
    endtask

    task automatic test_rr_wrap;
        int g;
        int want [3];
`ifdef ALU4_SCHED_FIXED_PRIO_EN
        want = '{3, 0, 0};
`else
        want = '{3, 0, 2};
`endif
        do_reset;
        do_txn(4'b1000, 0, g);
        tests++;
        if (g != want[0]) begin $display("FAIL wrap0 got %0d want %0d", g, want[0]); fails++; end
        do_txn(4'b0101, 0, g);
        tests++;
        if (g != want[1]) begin $display("FAIL wrap1 got %0d want %0d", g, want[1]); fails++; end
        do_txn(4'b0101, 0, g);
        tests++;
        if (g != want[2]) begin $display("FAIL wrap2 got %0d want %0d", g, want[2]); fails++; end
    endtask

    task automatic test_backpressure;
        int g;
        do_txn(4'b0010, 5, g);
    endtask

    task automatic test_reset_in_wait;
        int g;
        logic seen;
        do_reset;
        req_op = '1; req_a = '1; req_b = '1;
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin $display("FAIL rstwait_grant got %b want 0100", req_ready); fails++; end
        tick;
        tests++;
        if (busy !== 1'b1 || alu_a !== 4'hF) begin $display("FAIL rstwait_pre busy=%b a=%h want 1 f", busy, alu_a); fails++; end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || {alu_op, alu_a, alu_b} !== 11'b0 || req_ready !== 4'b0) begin
            $display("FAIL rstwait_async busy=%b v=%b alu=%h/%h/%h rdy=%b want 0", busy, rsp_valid, alu_op, alu_a, alu_b, req_ready); fails++;
        end
        req_valid = '0;
        #3 rst = 1'b0;
        ptr = NREQ - 1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin tick; if (rsp_valid !== 1'b0) seen = 1'b1; end
        tests++;
        if (seen) begin $display("FAIL rstwait_noresp got rsp_valid=1 want 0"); fails++; end
        do_txn(4'b1001, 0, g);
        tests++;
        if (g != 0) begin $display("FAIL rstwait_after got %0d want 0", g); fails++; end
    endtask

    task automatic test_random;
        int g;
        for (int n = 0; n < 12; n++) do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), g);
    endtask

    task automatic test_lat3;
        logic [3:0] saved;
        do_reset;
        req_op3 = 12'($urandom); req_a3 = 16'($urandom); req_b3 = 16'($urandom);
        req_valid3 = 4'b0100;
        #1;
        tests++;
        if (req_ready3 !== 4'b0100) begin $display("FAIL lat3_grant got %b want 0100", req_ready3); fails++; end
        rsp_ready = 1'b1;
        saved = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            if (k == 1) req_valid3 = '0;
            if (k == 3) saved = alu_result3;
            tests++;
            if (rsp_valid3 !== (k == 4)) begin
                $display("FAIL lat3_valid cyc=%0d got %b want %b", k, rsp_valid3, (k == 4)); fails++;
            end
        end
        tests++;
        if (rsp_data3 !== saved || rsp_id3 !== 2'd2) begin
            $display("FAIL lat3_data got d=%h id=%0d want d=%h id=2", rsp_data3, rsp_id3, saved); fails++;
        end
        tick;
        tests++;
        if (busy3 !== 1'b0) begin $display("FAIL lat3_idle got busy=%b want 0", busy3); fails++; end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_rr_wrap;
        test_backpressure;
        test_reset_in_wait;
        test_random;
        test_lat3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
